// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch unit for the cirno9 core. It holds the
//                architectural fetch PC and keeps at most one word fetch
//                outstanding on the instruction memory port. Each fetched
//                word is handed to the decoder, together with its PC, over
//                a val/rdy handshake. Redirects from the branch/jump unit
//                load a new PC. Any fetch already in flight at that point
//                is marked stale and its response is discarded.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   core clock, rising edge
//    rst_n          in   asynchronous active-low reset
//    i_setpc        in   redirect request (single-cycle)
//    i_pc           in   redirect base
//    i_pcadd        in   redirect offset (target = i_pc + i_pcadd)
//    hs_if4mem_val  out  fetch request valid
//    hs_mem4if_rdy  in   memory accepts request
//    o_mem_addr     out  fetch word address (bits [1:0] = 0)
//    hs_mem4if_rsp  in   read data valid
//    i_mem_rdata    in   fetched instruction word
//    hs_if4dec_val  out  instruction valid to decoder
//    hs_dec4if_rdy  in   decoder accepts instruction
//    o_ir           out  instruction word
//    o_ir_pc        out  PC of o_ir
// ============================================================================
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_setpc,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_pcadd,
   output logic        hs_if4mem_val,
   input  logic        hs_mem4if_rdy,
   output logic [31:0] o_mem_addr,
   input  logic        hs_mem4if_rsp,
   input  logic [31:0] i_mem_rdata,
   output logic        hs_if4dec_val,
   input  logic        hs_dec4if_rdy,
   output logic [31:0] o_ir,
   output logic [31:0] o_ir_pc
);

   localparam logic [31:0] c_nop      = 32'h0000_0013;
   localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_ir_pc;
   logic        r_stale;

   logic [31:0] w_sum;
   logic [31:0] w_target;

   assign w_sum    = i_pc + i_pcadd;
   assign w_target = {w_sum[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= c_reset_pc;
         r_ir    <= c_nop;
         r_ir_pc <= 32'h0000_0000;
         r_stale <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_REQ;
            end

            S_REQ: begin
               if (i_setpc) begin
                  r_pc <= w_target;
               end
               if (hs_mem4if_rdy) begin
                  r_state <= S_WAIT;
                  // The accepted request used the old PC; its data is
                  // useless when a redirect lands in the same cycle.
                  r_stale <= i_setpc;
               end
            end

            S_WAIT: begin
               if (i_setpc) begin
                  r_pc <= w_target;
               end
               if (hs_mem4if_rsp) begin
                  r_state <= S_REQ;
                  r_stale <= 1'b0;
                  // Keep the word only when the PC is still the one that
                  // was fetched: no earlier and no current redirect.
                  if (!r_stale && !i_setpc) begin
                     r_ir    <= i_mem_rdata;
                     r_ir_pc <= r_pc;
                     r_pc    <= r_pc + 32'd4;
                     r_state <= S_OUT;
                  end
               end else if (i_setpc) begin
                  r_stale <= 1'b1;
               end
            end

            S_OUT: begin
               // A redirect drops the held word even if the decoder takes
               // it in the same cycle.
               if (i_setpc) begin
                  r_pc    <= w_target;
                  r_state <= S_REQ;
               end else if (hs_dec4if_rdy) begin
                  r_state <= S_REQ;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign hs_if4mem_val = (r_state == S_REQ);
   assign hs_if4dec_val = (r_state == S_OUT);
   assign o_mem_addr    = r_pc;
   assign o_ir          = r_ir;
   assign o_ir_pc       = r_ir_pc;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch
//  Description : Directed testbench for ifu_fetch. A small memory model
//                returns addr-derived words with a programmable latency.
//                Accepted fetch addresses and consumed instructions are
//                logged and compared against hand-computed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

   localparam logic [31:0] c_nop  = 32'h0000_0013;
   localparam logic [31:0] c_bad  = 32'hDEAD_BEEF;
   localparam logic [31:0] c_junk = 32'hBAD0_0000;

   logic        clk;
   logic        rst_n;
   logic        setpc;
   logic [31:0] pc_in;
   logic [31:0] pcadd;
   logic        mem_val;
   logic        mem_rdy;
   logic [31:0] mem_addr;
   logic        mem_rsp;
   logic [31:0] mem_rdata;
   logic        dec_val;
   logic        dec_rdy;
   logic [31:0] ir;
   logic [31:0] ir_pc;

   ifu_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_setpc       (setpc),
      .i_pc          (pc_in),
      .i_pcadd       (pcadd),
      .hs_if4mem_val (mem_val),
      .hs_mem4if_rdy (mem_rdy),
      .o_mem_addr    (mem_addr),
      .hs_mem4if_rsp (mem_rsp),
      .i_mem_rdata   (mem_rdata),
      .hs_if4dec_val (dec_val),
      .hs_dec4if_rdy (dec_rdy),
      .o_ir          (ir),
      .o_ir_pc       (ir_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // memory model state
   logic        pending;
   logic [31:0] pend_addr;
   logic        pend_bad;
   logic        bad_next;
   logic        force_rsp;
   int          wait_cnt;
   int          lat;
   int          rdy_hold;
   logic        saw_bad;

   logic [31:0] acc[$];
   logic [31:0] cons_pc[$];
   logic [31:0] cons_ir[$];

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic step();
      logic        v_b;
      logic [31:0] a_b;
      mem_rsp   = force_rsp || (pending && wait_cnt == 0);
      mem_rdata = force_rsp ? c_junk : (pend_bad ? c_bad : mdata(pend_addr));
      mem_rdy   = (rdy_hold == 0);
      v_b = mem_val;
      a_b = mem_addr;
      if (dec_val && dec_rdy && !setpc) begin
         cons_pc.push_back(ir_pc);
         cons_ir.push_back(ir);
      end
      if (dec_val && ir == c_bad) saw_bad = 1'b1;
      @(posedge clk);
      if (mem_rsp) begin
         if (!force_rsp) pending = 1'b0;
      end else if (pending && wait_cnt > 0) begin
         wait_cnt--;
      end
      if (v_b && mem_rdy) begin
         pending   = 1'b1;
         pend_addr = a_b;
         wait_cnt  = lat - 1;
         pend_bad  = bad_next;
         bad_next  = 1'b0;
         acc.push_back(a_b);
      end
      if (rdy_hold > 0) rdy_hold--;
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic redirect(input logic [31:0] b, input logic [31:0] o);
      setpc = 1'b1;
      pc_in = b;
      pcadd = o;
      step();
      setpc = 1'b0;
   endtask

   task automatic do_reset(input bit chk);
      rst_n     = 1'b0;
      setpc     = 1'b0;
      pc_in     = '0;
      pcadd     = '0;
      dec_rdy   = 1'b1;
      mem_rdy   = 1'b1;
      mem_rsp   = 1'b0;
      mem_rdata = '0;
      pending   = 1'b0;
      pend_addr = '0;
      pend_bad  = 1'b0;
      bad_next  = 1'b0;
      force_rsp = 1'b0;
      wait_cnt  = 0;
      lat       = 1;
      rdy_hold  = 0;
      saw_bad   = 1'b0;
      acc.delete();
      cons_pc.delete();
      cons_ir.delete();
      #1;
      if (chk) begin
         check("rst_mem_val", {31'd0, mem_val}, 32'd0);
         check("rst_dec_val", {31'd0, dec_val}, 32'd0);
         check("rst_addr", mem_addr, 32'h0);
         check("rst_ir", ir, c_nop);
         check("rst_ir_pc", ir_pc, 32'h0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [9:0] pat;
   logic       unstable;

   initial begin
      rst_n = 1'b1;
      #1;
      do_reset(1'b1);

      // zero-wait streaming from reset
      for (int k = 0; k < 10; k++) begin
         pat[k] = dec_val;
         step();
      end
      check("stream_val_pattern", {22'd0, pat}, 32'h0000_0248);
      check("stream_acc_n", acc.size(), 32'd3);
      check("stream_acc2", acc[2], 32'h8);
      check("stream_cons_n", cons_pc.size(), 32'd3);
      check("stream_pc0", cons_pc[0], 32'h0);
      check("stream_pc1", cons_pc[1], 32'h4);
      check("stream_pc2", cons_pc[2], 32'h8);
      check("stream_ir1", cons_ir[1], mdata(32'h4));

      // redirect while holding PC 0x4, decoder ready in the same cycle
      do_reset(1'b0);
      steps(6);
      check("out_hold_pc", ir_pc, 32'h4);
      check("out_hold_val", {31'd0, dec_val}, 32'd1);
      redirect(32'h100, 32'hFFFF_FFF8);
      check("out_redir_addr", mem_addr, 32'hF8);
      check("out_redir_val", {31'd0, mem_val}, 32'd1);
      check("out_redir_decval", {31'd0, dec_val}, 32'd0);
      steps(3);
      check("out_cons_n", cons_pc.size(), 32'd2);
      check("out_cons_pc", cons_pc[1], 32'hF8);
      check("out_cons_ir", cons_ir[1], mdata(32'hF8));

      // redirect during a slow WAIT carrying bad data
      do_reset(1'b0);
      lat      = 3;
      bad_next = 1'b1;
      steps(2);
      lat = 1;
      redirect(32'h200, 32'h0);
      steps(2);
      check("wait_redir_addr", mem_addr, 32'h200);
      check("wait_redir_val", {31'd0, mem_val}, 32'd1);
      steps(3);
      check("wait_acc_n", acc.size(), 32'd2);
      check("wait_acc1", acc[1], 32'h200);
      check("wait_cons_n", cons_pc.size(), 32'd1);
      check("wait_cons_pc", cons_pc[0], 32'h200);
      check("wait_cons_ir", cons_ir[0], mdata(32'h200));
      check("wait_no_bad", {31'd0, saw_bad}, 32'd0);

      // redirect in the cycle the request is accepted
      do_reset(1'b0);
      step();
      redirect(32'h41, 32'h2);
      step();
      check("acc_redir_addr", mem_addr, 32'h40);
      steps(3);
      check("acc_acc_n", acc.size(), 32'd2);
      check("acc_acc1", acc[1], 32'h40);
      check("acc_cons_n", cons_pc.size(), 32'd1);
      check("acc_cons_pc", cons_pc[0], 32'h40);

      // memory and decoder back-pressure
      do_reset(1'b0);
      step();
      rdy_hold = 5;
      unstable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (mem_val !== 1'b1 || mem_addr !== 32'h0) unstable = 1'b1;
         step();
      end
      check("memstall_stable", {31'd0, unstable}, 32'd0);
      check("memstall_acc_n", acc.size(), 32'd0);
      step();
      dec_rdy = 1'b0;
      step();
      unstable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (dec_val !== 1'b1 || ir_pc !== 32'h0 || ir !== mdata(32'h0)) unstable = 1'b1;
         step();
      end
      check("decstall_stable", {31'd0, unstable}, 32'd0);
      check("decstall_cons_n", cons_pc.size(), 32'd0);
      dec_rdy = 1'b1;
      steps(7);
      check("stall_cons_n", cons_pc.size(), 32'd3);
      check("stall_cons0", cons_pc[0], 32'h0);
      check("stall_cons1", cons_pc[1], 32'h4);
      check("stall_cons2", cons_pc[2], 32'h8);
      check("stall_acc_n", acc.size(), 32'd3);

      // PC wrap at the top of the address space
      do_reset(1'b0);
      step();
      rdy_hold = 1;
      redirect(32'hFFFF_FFFC, 32'h0);
      check("wrap_redir_addr", mem_addr, 32'hFFFF_FFFC);
      steps(3);
      check("wrap_acc0", acc[0], 32'hFFFF_FFFC);
      check("wrap_cons_pc", cons_pc[0], 32'hFFFF_FFFC);
      check("wrap_next_addr", mem_addr, 32'h0);
      check("wrap_next_val", {31'd0, mem_val}, 32'd1);

      // spurious response in IDLE, then async reset mid-WAIT
      do_reset(1'b0);
      force_rsp = 1'b1;
      step();
      force_rsp = 1'b0;
      steps(4);
      check("idle_rsp_cons_ir", cons_ir[0], mdata(32'h0));
      check("midwait_addr", mem_addr, 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_mem_val", {31'd0, mem_val}, 32'd0);
      check("async_dec_val", {31'd0, dec_val}, 32'd0);
      check("async_addr", mem_addr, 32'h0);
      check("async_ir", ir, c_nop);
      check("async_ir_pc", ir_pc, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
